// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the data word and the memory-stage controller states.
// The LLSC_EN build option (see mem_stage_ctrl.sv) adds nothing here.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } memctl_state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-cache request/response bus between the MEM stage (master) and the dcache (slave).
interface mem_stage_ctrl_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );

endinterface

// File: rtl/link_reg.sv
// LL/SC link register: holds the linked address, reports a match for the current
// instruction, and drops the link on SC, a store to the linked word, or a snoop hit.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  word_t addr,
  input  logic  ll_adv,
  input  logic  sc_adv,
  input  logic  st_adv,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  output logic  match
);

  logic  link_valid;
  word_t link_addr;

  // A new link takes priority over a same-cycle snoop invalidate.
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (ll_adv) begin
      link_valid <= 1'b1;
      link_addr  <= addr;
    end else if (sc_adv
                 || (st_adv && addr == link_addr)
                 || (snoop_inv && snoop_addr == link_addr)) begin
      link_valid <= 1'b0;
    end
  end

  assign match = link_valid && (addr == link_addr);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues the dcache access for EX/MEM, buffers load data while
// the pipe is frozen, drives MEM/WB enable/flush, halt tracking and a stall counter.
// Define LLSC_EN to build the LL/SC link register; otherwise LL/SC act as load/store.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 exmem_valid,
  input  logic                 dren_in,
  input  logic                 dwen_in,
  input  logic                 ll_in,
  input  logic                 sc_in,
  input  logic                 halt_in,
  input  word_t                addr_in,
  input  word_t                store_in,
  input  logic                 ext_stall,
  mem_stage_ctrl_if.master     dcif,
  input  logic                 snoop_inv,
  input  word_t                snoop_addr,
  output word_t                dmemload_out,
  output logic                 sc_result,
  output logic                 mem_stall,
  output logic                 memwb_enable,
  output logic                 memwb_flush,
  output logic                 halt_seen,
  output logic [CNT_W-1:0]     stall_cnt
);

  memctl_state_t state, next_state;
  word_t         load_buf;
  logic          req;
  logic          mem_req;
  logic          advance;

  assign req = exmem_valid && (dren_in || dwen_in) && !halt_seen;

`ifdef LLSC_EN
  logic link_ok;

  link_reg u_link_reg (
    .CLK        (CLK),
    .RST        (RST),
    .addr       (addr_in),
    .ll_adv     (advance && ll_in),
    .sc_adv     (advance && sc_in),
    .st_adv     (advance && dwen_in && !sc_in),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .match      (link_ok)
  );

  // A failed SC never reaches the cache, so it costs no stall cycles.
  assign mem_req   = req && !(sc_in && !link_ok);
  assign sc_result = link_ok;
`else
  logic unused_llsc;

  assign unused_llsc = ^{ll_in, sc_in, snoop_inv, snoop_addr};
  assign mem_req     = req;
  assign sc_result   = 1'b1;
`endif

  assign dcif.dmemaddr  = addr_in;
  assign dcif.dmemstore = store_in;
  assign memwb_enable   = !ext_stall;
  assign memwb_flush    = mem_stall && !ext_stall;
  assign advance        = exmem_valid && !mem_stall && !ext_stall;

  always_comb begin
    next_state    = state;
    dcif.dmemREN  = 1'b0;
    dcif.dmemWEN  = 1'b0;
    mem_stall     = 1'b0;
    dmemload_out  = dcif.dmemload;
    unique case (state)
      IDLE, WAIT: begin
        dcif.dmemREN = mem_req && dren_in;
        dcif.dmemWEN = mem_req && dwen_in;
        mem_stall    = mem_req && !dcif.dhit;
        if (mem_req && dcif.dhit) next_state = ext_stall ? DONE : IDLE;
        else if (mem_req)         next_state = WAIT;
      end
      DONE: begin
        dmemload_out = load_buf;
        if (!ext_stall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      load_buf  <= '0;
      halt_seen <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (state != DONE && mem_req && dcif.dhit && ext_stall) load_buf <= dcif.dmemload;
      if (advance && halt_in) halt_seen <= 1'b1;
      if (mem_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a per-instruction
// behavioural model, preceded by directed scenarios with hand-computed expectations.
module tb_mem_stage_ctrl;

  localparam int unsigned TB_CNT_W = 4;
  localparam int unsigned CMAX     = (1 << TB_CNT_W) - 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                RST;
  logic                exmem_valid, dren_in, dwen_in, ll_in, sc_in, halt_in;
  logic [31:0]         addr_in, store_in, snoop_addr;
  logic                ext_stall, snoop_inv;
  logic [31:0]         dmemload_out;
  logic                sc_result, mem_stall, memwb_enable, memwb_flush, halt_seen;
  logic [TB_CNT_W-1:0] stall_cnt;

  mem_stage_ctrl_if dcif ();

  mem_stage_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .exmem_valid  (exmem_valid),
    .dren_in      (dren_in),
    .dwen_in      (dwen_in),
    .ll_in        (ll_in),
    .sc_in        (sc_in),
    .halt_in      (halt_in),
    .addr_in      (addr_in),
    .store_in     (store_in),
    .ext_stall    (ext_stall),
    .dcif         (dcif),
    .snoop_inv    (snoop_inv),
    .snoop_addr   (snoop_addr),
    .dmemload_out (dmemload_out),
    .sc_result    (sc_result),
    .mem_stall    (mem_stall),
    .memwb_enable (memwb_enable),
    .memwb_flush  (memwb_flush),
    .halt_seen    (halt_seen),
    .stall_cnt    (stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model: m_done means the current instruction's cache access already completed
  // under a freeze and its data sits in m_buf.
  bit          m_done, m_halt, lk_v;
  logic [31:0] m_buf, lk_a;
  int unsigned m_cnt;
  logic        e_req, e_stall, e_adv, e_match;
  bit          moved;

  logic [31:0] addr_set [4] = '{32'h40, 32'h80, 32'h100, 32'h104};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_done = 0; m_halt = 0; lk_v = 0; m_buf = '0; lk_a = '0; m_cnt = 0;
  endtask

  task automatic set_instr(input logic v, rd, wr, ll, sc, hl, input logic [31:0] a, s);
    exmem_valid = v; dren_in = rd; dwen_in = wr; ll_in = ll; sc_in = sc; halt_in = hl;
    addr_in = a; store_in = s;
  endtask

  task automatic settle();
    bit sc_fail;
    #1;
    e_match = lk_v && (addr_in == lk_a);
`ifdef LLSC_EN
    sc_fail = sc_in && !e_match;
`else
    sc_fail = 1'b0;
`endif
    e_req   = exmem_valid && (dren_in || dwen_in) && !m_halt && !sc_fail;
    e_stall = e_req && !dcif.dhit && !m_done;
    e_adv   = exmem_valid && !e_stall && !ext_stall;
    chk("dmemREN",  dcif.dmemREN, e_req && dren_in && !m_done);
    chk("dmemWEN",  dcif.dmemWEN, e_req && dwen_in && !m_done);
    chk("dmemaddr", dcif.dmemaddr, addr_in);
    chk("dmemstore", dcif.dmemstore, store_in);
    chk("dmemload_out", dmemload_out, m_done ? m_buf : dcif.dmemload);
    chk("mem_stall", mem_stall, e_stall);
    chk("memwb_enable", memwb_enable, !ext_stall);
    chk("memwb_flush", memwb_flush, e_stall && !ext_stall);
    chk("halt_seen", halt_seen, m_halt);
    chk("stall_cnt", stall_cnt, m_cnt);
`ifdef LLSC_EN
    if (exmem_valid && sc_in) chk("sc_result", sc_result, e_match);
`else
    chk("sc_result", sc_result, 1);
`endif
  endtask

  task automatic adv();
    @(posedge CLK);
    if (RST) begin
      model_reset();
      moved = 1;
    end else begin
      if (e_stall && m_cnt < CMAX) m_cnt++;
      if (m_done) begin
        if (!ext_stall) m_done = 0;
      end else if (e_req && dcif.dhit && ext_stall) begin
        m_done = 1;
        m_buf  = dcif.dmemload;
      end
      if (e_adv && halt_in) m_halt = 1;
`ifdef LLSC_EN
      if (e_adv && ll_in) begin
        lk_v = 1; lk_a = addr_in;
      end else if ((e_adv && sc_in) || (e_adv && dwen_in && !sc_in && addr_in == lk_a)
                   || (snoop_inv && snoop_addr == lk_a)) begin
        lk_v = 0;
      end
`endif
      moved = !ext_stall && !e_stall;
    end
    @(negedge CLK);
  endtask

  task automatic bubble();
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    dcif.dhit = 0;
  endtask

  task automatic pick_instr();
    int unsigned k;
    logic [31:0] a, s, r;
    k = $urandom % 64;
    a = addr_set[$urandom % 4];
    s = $urandom;
    r = $urandom;
    if      (k < 12) set_instr(0, r[0], r[1], 0, 0, 0, a, s);
    else if (k < 30) set_instr(1, 1, 0, 0, 0, 0, a, s);
    else if (k < 44) set_instr(1, 0, 1, 0, 0, 0, a, s);
    else if (k < 52) set_instr(1, 1, 0, 1, 0, 0, a, s);
    else if (k < 60) set_instr(1, 0, 1, 0, 1, 0, a, s);
    else if (k < 63) set_instr(1, 0, 0, 0, 0, 0, a, s);
    else             set_instr(1, 0, 0, 0, 0, 1, a, s);
  endtask

  initial begin
    RST = 1; ext_stall = 0; snoop_inv = 0; snoop_addr = '0;
    dcif.dhit = 0; dcif.dmemload = '0;
    bubble();
    repeat (2) @(posedge CLK);
    model_reset();
    @(negedge CLK);

    // reset state
    settle();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_halt", halt_seen, 0);
    chk("rst_ren", dcif.dmemREN, 0);
    adv();
    RST = 0;

    // LW 0x40, zero-stall hit
    set_instr(1, 1, 0, 0, 0, 0, 32'h40, 32'h0);
    dcif.dhit = 1; dcif.dmemload = 32'hDEADBEEF;
    settle();
    chk("lw_stall", mem_stall, 0);
    chk("lw_load", dmemload_out, 32'hDEADBEEF);
    chk("lw_ren", dcif.dmemREN, 1);
    adv();
    bubble(); settle();
    chk("lw_cnt", stall_cnt, 0);
    adv();

    // SW 0x80, hit after 3 cycles
    set_instr(1, 0, 1, 0, 0, 0, 32'h80, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("sw_stall", mem_stall, 1);
      chk("sw_flush", memwb_flush, 1);
      chk("sw_wen", dcif.dmemWEN, 1);
      adv();
    end
    dcif.dhit = 1;
    settle();
    chk("sw_wen_hit", dcif.dmemWEN, 1);
    chk("sw_stall_hit", mem_stall, 0);
    adv();
    bubble(); settle();
    chk("sw_cnt", stall_cnt, 3);
    adv();

    // LW hit under a 4-cycle external freeze
    set_instr(1, 1, 0, 0, 0, 0, 32'h44, 32'h0);
    dcif.dhit = 1; ext_stall = 1; dcif.dmemload = 32'hCAFE0001;
    settle();
    chk("frz_ren", dcif.dmemREN, 1);
    chk("frz_stall", mem_stall, 0);
    adv();
    dcif.dhit = 0;
    for (int i = 0; i < 3; i++) begin
      dcif.dmemload = $urandom;
      settle();
      chk("done_ren", dcif.dmemREN, 0);
      chk("done_load", dmemload_out, 32'hCAFE0001);
      adv();
    end
    ext_stall = 0;
    settle();
    chk("done_release", dmemload_out, 32'hCAFE0001);
    chk("done_enable", memwb_enable, 1);
    adv();
    bubble(); settle(); adv();

`ifdef LLSC_EN
    set_instr(1, 1, 0, 1, 0, 0, 32'h100, 32'h0); dcif.dhit = 1;
    settle(); adv();
    set_instr(1, 0, 1, 0, 1, 0, 32'h100, 32'h55); dcif.dhit = 1;
    settle();
    chk("sc_ok_wen", dcif.dmemWEN, 1);
    chk("sc_ok_res", sc_result, 1);
    adv();
    set_instr(1, 1, 0, 1, 0, 0, 32'h100, 32'h0); dcif.dhit = 1;
    settle(); adv();
    bubble(); snoop_inv = 1; snoop_addr = 32'h100;
    settle(); adv();
    snoop_inv = 0;
    set_instr(1, 0, 1, 0, 1, 0, 32'h100, 32'h66); dcif.dhit = 0;
    settle();
    chk("sc_fail_wen", dcif.dmemWEN, 0);
    chk("sc_fail_res", sc_result, 0);
    chk("sc_fail_stall", mem_stall, 0);
    adv();
`else
    set_instr(1, 0, 1, 0, 1, 0, 32'h100, 32'h55); dcif.dhit = 1;
    settle();
    chk("sc_as_store_wen", dcif.dmemWEN, 1);
    chk("sc_tied", sc_result, 1);
    adv();
`endif
    bubble(); settle(); adv();

    // halt commits, then a later load is suppressed
    set_instr(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    settle(); adv();
    set_instr(1, 1, 0, 0, 0, 0, 32'h40, 32'h0);
    settle();
    chk("halt_seen", halt_seen, 1);
    chk("halt_ren", dcif.dmemREN, 0);
    chk("halt_stall", mem_stall, 0);
    adv();

    // counter saturation, then reset in the middle of a wait
    bubble(); RST = 1; settle(); adv(); RST = 0;
    set_instr(1, 1, 0, 0, 0, 0, 32'h40, 32'h0);
    for (int i = 0; i < 18; i++) begin settle(); adv(); end
    settle();
    chk("sat_cnt", stall_cnt, 15);
    chk("wait_ren", dcif.dmemREN, 1);
    RST = 1;
    settle(); adv();
    RST = 0; bubble();
    settle();
    chk("rstw_cnt", stall_cnt, 0);
    chk("rstw_ren", dcif.dmemREN, 0);
    chk("rstw_wen", dcif.dmemWEN, 0);
    adv();
    set_instr(1, 1, 0, 0, 0, 0, 32'h40, 32'h0); dcif.dhit = 1;
    settle();
    chk("rstw_idle_hit", mem_stall, 0);
    adv();

    // randomized phase
    moved = 1;
    for (int c = 0; c < 3000; c++) begin
      if (moved) pick_instr();
      ext_stall     = ($urandom % 4) == 0;
      dcif.dhit     = ($urandom % 3) == 0;
      dcif.dmemload = $urandom;
      snoop_inv     = !sc_in && (($urandom % 8) == 0);
      snoop_addr    = addr_set[$urandom % 4];
      RST           = (($urandom % 150) == 0) || (m_halt && (($urandom % 20) == 0));
      settle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller between the EX/MEM latch and the MEM/WB latch.
- Issues the data-cache request for the instruction held in EX/MEM and waits for dhit.
- Buffers the load word when the rest of the pipe is frozen, and drives MEM/WB enable/flush plus the MEM-stage stall to hazard logic.
- Tracks halt and a saturating stall-cycle counter.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
exmem_valid  in  1  EX/MEM holds a real (non-bubble) instruction
dren_in  in  1  instruction is a load
dwen_in  in  1  instruction is a store
ll_in  in  1  load-linked
sc_in  in  1  store-conditional
halt_in  in  1  instruction is halt
addr_in  in  32 (word_t)  data address
store_in  in  32 (word_t)  store data
ext_stall  in  1  stall from elsewhere (icache miss); freezes EX/MEM and MEM/WB
dhit  in  1  dcache completed request this cycle
dmemload  in  32  dcache read data
snoop_inv  in  1  coherence invalidate seen
snoop_addr  in  32  invalidated address
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  32  request address (addr_in)
dmemstore  out  32  request data (store_in)
dmemload_out  out  32  load word to MEM/WB dmemload_in
sc_result  out  1  SC success flag (1 = success)
mem_stall  out  1  MEM stage waiting on cache
memwb_enable  out  1  MEM/WB latch enable
memwb_flush  out  1  MEM/WB latch loads bubble
halt_seen  out  1  halt has committed past MEM
stall_cnt  out  CNT_W  saturating count of mem_stall cycles

Behaviour:
- States:
  - IDLE: no outstanding request.
  - WAIT: request issued, no dhit yet.
  - DONE: dhit received while ext_stall=1; result buffered.
- Request: req = exmem_valid & (dren_in|dwen_in) & !halt_seen.
  - dmemREN/dmemWEN asserted combinationally in IDLE and WAIT when req.
  - Never asserted in DONE.
  - For SC, the write is gated by the link (see Optional Feature).
- IDLE:
  - req & dhit & !ext_stall: zero-stall access; dmemload_out=dmemload; stay IDLE.
  - req & dhit & ext_stall: capture dmemload into buf; go to DONE.
  - req & !dhit: go to WAIT.
- WAIT: dhit & !ext_stall → IDLE (data passed through); dhit & ext_stall → DONE (buffered); else stay.
- DONE: dmemload_out=buf; go to IDLE on the first cycle ext_stall=0.
- mem_stall = req & !dhit & state≠DONE.
- memwb_enable = !ext_stall.
- memwb_flush = mem_stall & !ext_stall, inserting a bubble into WB.
- Advance (EX/MEM instruction leaves MEM) = exmem_valid & !mem_stall & !ext_stall.
- halt_seen: set on an advance with halt_in=1; sticky until RST. While set, requests are suppressed and memwb_enable remains driven.
- stall_cnt: +1 each cycle mem_stall=1; saturates at all-ones.
- dhit outside IDLE/WAIT-with-req is ignored.
- Reset (synchronous) values: state=IDLE, buf=0, halt_seen=0, stall_cnt=0, link cleared. Combinational outputs follow from these.
- Reset mid-WAIT abandons the request; the request drops in the cycle after the RST edge.

Optional Feature:
LLSC_EN
- Enabled:
  - Link register (valid, addr) is set by an LL advance.
  - SC with valid & addr match issues a write and returns sc_result=1.
  - On mismatch, SC issues no write, sc_result=0, and it takes zero stall cycles.
  - Link is cleared by: any SC advance; a non-SC store advance to the link address; snoop_inv with snoop_addr==link addr.
  - Same-cycle LL set and snoop_inv clear: set wins.
- Disabled: LL behaves as load, SC as store, sc_result tied 1, snoop ports unused.

Decomposition:
- memctl_state_t enum (IDLE, WAIT, DONE) goes in cpu_types_pkg, alongside the existing word_t.
- One sub-module, link_reg: link valid/address storage, match, and clear logic; instantiated only under LLSC_EN.

Test Plan:
- LW addr 0x40, dhit same cycle, ext_stall=0 → mem_stall=0, dmemload_out=dmemload=0xDEADBEEF, stall_cnt stays 0.
- SW addr 0x80, dhit after 3 cycles → mem_stall=1 for 3 cycles, memwb_flush=1 for 3 cycles, stall_cnt=3, dmemWEN held until dhit.
- LW, dhit=0xCAFE0001 arrives while ext_stall=1 for 4 cycles → state DONE, dmemREN=0 during DONE, dmemload_out=0xCAFE0001 when ext_stall drops.
- Halt advance, then a subsequent LW presented → halt_seen=1, dmemREN stays 0.
- LLSC_EN: LL 0x100 then SC 0x100 → write issued, sc_result=1. LL 0x100, snoop_inv 0x100, SC 0x100 → no write, sc_result=0, mem_stall=0.
- RST asserted during WAIT → next cycle state IDLE, stall_cnt=0, dmemREN/dmemWEN=0 while exmem_valid=0.
